assert_monitor_bank: RTL and testbench

- Synthesizable, multi-channel runtime property checker with disable support.
- Each channel samples a boolean check expression when its enable is high. It counts passes and failures, and records the first failure (channel and cycle).
- Checks are suppressed while reset is asserted, during a hold-off window after reset, and while a per-channel disable is high.
- Per-channel mode selects an immediate check or a deferred check. A deferred check is flushed if a disable arrives before it resolves.
- Sits beside a DUT in sim or FPGA debug builds and feeds a status/CSR block.

---
 rtl/assert_monitor_pkg.sv | 24 ++
 rtl/assert_monitor_chan.sv | 69 ++++++
 rtl/assert_monitor_bank.sv | 100 ++++++++++
 tb/tb_assert_monitor_bank.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/assert_monitor_pkg.sv
// Shared definitions for the assertion monitor bank: FSM encodings and small helpers.
package assert_monitor_pkg;

  localparam logic [1:0] ST_HOLDOFF = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_FROZEN  = 2'd2;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] lim;
    lim = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
    return (value >= lim) ? lim : value + 32'd1;
  endfunction

  function automatic logic [4:0] lowest_set_index(input logic [31:0] vec);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/assert_monitor_chan.sv
// One check channel: optional one-deep deferred stage, saturating pass/fail counters, sticky flag.
module assert_monitor_chan
  import assert_monitor_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter bit          DEFERRED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             armed,
  input  logic             frozen,
  input  logic             dis,
  input  logic             en,
  input  logic             val,
  output logic             res_fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_sticky
);

  logic ok;
  logic eff;
  logic res_vld;
  logic res_pass;

  assign ok  = ~dis & ~clr & ~frozen;
  assign eff = armed & en & ok;

  if (DEFERRED) begin : g_def
    logic pend;
    logic pval;

    // The entry is rewritten every cycle; a gap in eff simply drops it.
    always_ff @(posedge clk) begin
      if (rst) begin
        pend <= 1'b0;
        pval <= 1'b0;
      end else begin
        pend <= eff;
        pval <= val;
      end
    end

    assign res_vld  = pend & ok;
    assign res_pass = pval;
  end else begin : g_imm
    assign res_vld  = eff;
    assign res_pass = val;
  end

  assign res_fail = res_vld & ~res_pass;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      fail_sticky <= 1'b0;
    end else if (res_vld) begin
      if (res_pass) begin
        pass_cnt <= CNT_W'(sat_inc(32'(pass_cnt), CNT_W));
      end else begin
        fail_cnt    <= CNT_W'(sat_inc(32'(fail_cnt), CNT_W));
        fail_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/assert_monitor_bank.sv
// Multi-channel runtime property checker: hold-off/armed/frozen control, timestamp, first-fail record.
module assert_monitor_bank
  import assert_monitor_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned TS_W          = 32,
  parameter int unsigned HOLDOFF       = 3,
  parameter logic [31:0] DEFERRED_MASK = 32'b0,
  parameter bit          STOP_ON_FAIL  = 1'b0,
  localparam int unsigned CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [N_CH-1:0]       ch_dis,
  input  logic [N_CH-1:0]       chk_en,
  input  logic [N_CH-1:0]       chk_val,
  output logic [N_CH*CNT_W-1:0] pass_cnt,
  output logic [N_CH*CNT_W-1:0] fail_cnt,
  output logic [N_CH-1:0]       fail_sticky,
  output logic                  any_fail,
  output logic                  fail_pulse,
  output logic                  first_fail_vld,
  output logic [CH_W-1:0]       first_fail_ch,
  output logic [TS_W-1:0]       first_fail_ts,
  output logic                  armed
);

  logic [1:0]      state;
  logic [31:0]     hcnt;
  logic [TS_W-1:0] ts;
  logic [N_CH-1:0] fail_ev;
  logic            frozen;

  assign armed    = (state == ST_ARMED);
  assign frozen   = (state == ST_FROZEN);
  assign any_fail = |fail_sticky;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (HOLDOFF == 0) ? ST_ARMED : ST_HOLDOFF;
      hcnt  <= HOLDOFF;
    end else begin
      case (state)
        ST_HOLDOFF: begin
          if (hcnt == 32'd0) state <= ST_ARMED;
          else               hcnt  <= hcnt - 32'd1;
        end
        ST_ARMED:  if (STOP_ON_FAIL && (|fail_ev)) state <= ST_FROZEN;
        ST_FROZEN: if (clr) state <= ST_ARMED;
        default:   state <= ST_HOLDOFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + TS_W'(1);
  end

  // The recorded timestamp is the value ts takes at the commit edge.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      first_fail_vld <= 1'b0;
      first_fail_ch  <= '0;
      first_fail_ts  <= '0;
      fail_pulse     <= 1'b0;
    end else begin
      fail_pulse <= 1'b0;
      if ((|fail_ev) && !first_fail_vld) begin
        first_fail_vld <= 1'b1;
        first_fail_ch  <= CH_W'(lowest_set_index(32'(fail_ev)));
        first_fail_ts  <= ts + TS_W'(1);
        fail_pulse     <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assert_monitor_chan #(
      .CNT_W   (CNT_W),
      .DEFERRED(DEFERRED_MASK[i])
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .armed      (armed),
      .frozen     (frozen),
      .dis        (ch_dis[i]),
      .en         (chk_en[i]),
      .val        (chk_val[i]),
      .res_fail   (fail_ev[i]),
      .pass_cnt   (pass_cnt[i*CNT_W +: CNT_W]),
      .fail_cnt   (fail_cnt[i*CNT_W +: CNT_W]),
      .fail_sticky(fail_sticky[i])
    );
  end

endmodule

// File: tb/tb_assert_monitor_bank.sv
// Bench for assert_monitor_bank: two configurations driven in parallel against a cycle model.
module tb_assert_monitor_bank;

  localparam int NCH  = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst, clr;
  logic [NCH-1:0] ch_dis, chk_en, chk_val;

  logic [NCH*CW-1:0] o_pass [2];
  logic [NCH*CW-1:0] o_fail [2];
  logic [NCH-1:0]    o_sticky [2];
  logic              o_any [2];
  logic              o_pulse [2];
  logic              o_vld [2];
  logic [1:0]        o_ch [2];
  logic [31:0]       o_ts [2];
  logic              o_armed [2];

  always #5 clk = ~clk;

  assert_monitor_bank #(
    .N_CH(NCH), .CNT_W(CW), .TS_W(32), .HOLDOFF(3), .DEFERRED_MASK(32'h2), .STOP_ON_FAIL(1'b0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .ch_dis(ch_dis), .chk_en(chk_en), .chk_val(chk_val),
    .pass_cnt(o_pass[0]), .fail_cnt(o_fail[0]), .fail_sticky(o_sticky[0]), .any_fail(o_any[0]),
    .fail_pulse(o_pulse[0]), .first_fail_vld(o_vld[0]), .first_fail_ch(o_ch[0]),
    .first_fail_ts(o_ts[0]), .armed(o_armed[0])
  );

  assert_monitor_bank #(
    .N_CH(NCH), .CNT_W(CW), .TS_W(32), .HOLDOFF(0), .DEFERRED_MASK(32'hc), .STOP_ON_FAIL(1'b1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .ch_dis(ch_dis), .chk_en(chk_en), .chk_val(chk_val),
    .pass_cnt(o_pass[1]), .fail_cnt(o_fail[1]), .fail_sticky(o_sticky[1]), .any_fail(o_any[1]),
    .fail_pulse(o_pulse[1]), .first_fail_vld(o_vld[1]), .first_fail_ch(o_ch[1]),
    .first_fail_ts(o_ts[1]), .armed(o_armed[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input longint unsigned got,
                           input longint unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state, one set per configuration.
  int          p_hold [2] = '{3, 0};
  bit [3:0]    p_def  [2] = '{4'b0010, 4'b1100};
  bit          p_stop [2] = '{1'b0, 1'b1};

  int          m_pass   [2][NCH];
  int          m_fail   [2][NCH];
  bit          m_sticky [2][NCH];
  bit          m_pend   [2][NCH];
  bit          m_pval   [2][NCH];
  bit          m_frozen [2];
  int          m_k      [2];
  bit          m_vld    [2];
  int          m_ch     [2];
  longint      m_ts     [2];
  longint      m_fts    [2];
  bit          m_pulse  [2];

  function automatic bit model_armed(input int j);
    int arm_at;
    arm_at = (p_hold[j] == 0) ? 0 : p_hold[j] + 1;
    return !m_frozen[j] && (m_k[j] >= arm_at);
  endfunction

  task automatic model_step(input int j);
    bit arm, commit, pass, np;
    int low;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_pass[j][c] = 0; m_fail[j][c] = 0; m_sticky[j][c] = 0;
        m_pend[j][c] = 0; m_pval[j][c] = 0;
      end
      m_frozen[j] = 0; m_k[j] = 0; m_vld[j] = 0; m_ch[j] = 0;
      m_ts[j] = 0; m_fts[j] = 0; m_pulse[j] = 0;
      return;
    end
    arm = model_armed(j);
    low = -1;
    for (int c = 0; c < NCH; c++) begin
      if (p_def[j][c]) begin
        commit = m_pend[j][c] && !ch_dis[c] && !clr && !m_frozen[j];
        pass   = m_pval[j][c];
      end else begin
        commit = arm && chk_en[c] && !ch_dis[c] && !clr;
        pass   = chk_val[c];
      end
      np = p_def[j][c] && arm && chk_en[c] && !ch_dis[c] && !clr;
      if (clr) begin
        m_pass[j][c] = 0; m_fail[j][c] = 0; m_sticky[j][c] = 0;
      end else if (commit) begin
        if (pass) begin
          if (m_pass[j][c] < CMAX) m_pass[j][c]++;
        end else begin
          if (m_fail[j][c] < CMAX) m_fail[j][c]++;
          m_sticky[j][c] = 1;
          if (low < 0) low = c;
        end
      end
      m_pend[j][c] = np;
      m_pval[j][c] = chk_val[c];
    end
    if (clr) begin
      m_vld[j] = 0; m_ch[j] = 0; m_fts[j] = 0; m_pulse[j] = 0; m_frozen[j] = 0;
    end else begin
      m_pulse[j] = 0;
      if (low >= 0 && !m_vld[j]) begin
        m_vld[j] = 1; m_ch[j] = low; m_fts[j] = (m_ts[j] + 1) & 64'hffff_ffff; m_pulse[j] = 1;
      end
      if (p_stop[j] && low >= 0) m_frozen[j] = 1;
    end
    m_ts[j] = (m_ts[j] + 1) & 64'hffff_ffff;
    m_k[j]++;
  endtask

  task automatic compare(input int j);
    bit anyf;
    anyf = 0;
    for (int c = 0; c < NCH; c++) begin
      check_val($sformatf("d%0d.pass%0d", j, c), o_pass[j][c*CW +: CW], m_pass[j][c]);
      check_val($sformatf("d%0d.fail%0d", j, c), o_fail[j][c*CW +: CW], m_fail[j][c]);
      check_val($sformatf("d%0d.sticky%0d", j, c), o_sticky[j][c], m_sticky[j][c]);
      anyf |= m_sticky[j][c];
    end
    check_val($sformatf("d%0d.any_fail", j), o_any[j], anyf);
    check_val($sformatf("d%0d.fail_pulse", j), o_pulse[j], m_pulse[j]);
    check_val($sformatf("d%0d.ff_vld", j), o_vld[j], m_vld[j]);
    check_val($sformatf("d%0d.ff_ch", j), o_ch[j], m_ch[j]);
    check_val($sformatf("d%0d.ff_ts", j), o_ts[j], m_fts[j]);
    check_val($sformatf("d%0d.armed", j), o_armed[j], model_armed(j));
  endtask

  task automatic step();
    @(posedge clk);
    for (int j = 0; j < 2; j++) model_step(j);
    #1;
    for (int j = 0; j < 2; j++) compare(j);
  endtask

  task automatic idle(input int n);
    chk_en = '0; ch_dis = '0; clr = 1'b0; rst = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clr();
    chk_en = '0; ch_dis = '0; clr = 1'b1; rst = 1'b0;
    step();
    clr = 1'b0;
  endtask

  int npulse;

  initial begin
    // Reset hold-off: rst for cycles 0-4, failing checks requested throughout.
    clr = 1'b0; ch_dis = '0; chk_en = '1; chk_val = '0;
    for (int c = 0; c < 10; c++) begin
      rst = (c < 5);
      step();
      if (c == 8) check_val("holdoff_none", o_fail[0][0 +: CW], 0);
      if (c == 9) begin
        check_val("holdoff_first", o_fail[0][0 +: CW], 1);
        check_val("holdoff_ts", o_ts[0], 5);
        check_val("holdoff_ch", o_ch[0], 0);
      end
    end

    // Immediate alternating pass/fail on ch0.
    do_clr();
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      chk_en = 4'b0001; chk_val = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      step();
      if (o_pulse[0]) npulse++;
    end
    idle(1);
    if (o_pulse[0]) npulse++;
    check_val("alt_pass", o_pass[0][0 +: CW], 5);
    check_val("alt_fail", o_fail[0][0 +: CW], 5);
    check_val("alt_pulses", npulse, 1);

    // Deferred ch1 flushed by a one-cycle disable between capture and commit.
    do_clr();
    chk_en = 4'b0010; chk_val = 4'b0000; step();
    chk_en = 4'b0000; ch_dis = 4'b0010; step();
    idle(2);
    check_val("flush_fail1", o_fail[0][1*CW +: CW], 0);
    check_val("flush_sticky1", o_sticky[0][1], 0);

    // Same-cycle failures on ch2/ch3, then a later ch0 failure.
    do_clr();
    chk_en = 4'b1100; chk_val = 4'b0000; step();
    idle(2);
    check_val("prio_ch", o_ch[0], 2);
    check_val("prio_ch_def", o_ch[1], 2);
    chk_en = 4'b0001; chk_val = 4'b0000; step();
    idle(1);
    check_val("prio_keep", o_ch[0], 2);
    check_val("prio_fail0", o_fail[0][0 +: CW], 1);

    // Saturation on dut0, freeze on dut1, then clear.
    do_clr();
    for (int i = 0; i < 20; i++) begin
      chk_en = 4'b0001; chk_val = 4'b0000; step();
    end
    idle(1);
    check_val("sat_fail0", o_fail[0][0 +: CW], 15);
    check_val("frz_fail0", o_fail[1][0 +: CW], 1);
    check_val("frz_armed", o_armed[1], 0);
    do_clr();
    check_val("clr_fail", o_fail[1], 0);
    check_val("clr_pass", o_pass[1], 0);
    check_val("clr_armed", o_armed[1], 1);

    // clr coinciding with a failing check.
    chk_en = 4'b0001; chk_val = 4'b0000; clr = 1'b1; step();
    idle(1);
    check_val("coll_fail0", o_fail[0][0 +: CW], 0);
    check_val("coll_vld", o_vld[0], 0);

    // Randomized traffic including occasional rst and clr.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(199) == 0);
      clr     = ($urandom_range(39) == 0);
      chk_en  = 4'($urandom);
      chk_val = 4'($urandom);
      ch_dis  = 4'($urandom) & 4'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
